npu_axil_master: RTL and testbench

AXI4-Lite initiator that turns single register commands (one write or one read) into AXI4-Lite transactions. It is the host-side counterpart of the NPU control-register responder and drives the s_axi_* port of npu_top in synthesizable self-test and debug-loader configurations. It allows one outstanding transaction, buffers one response, and has a stall timeout.

---
 rtl/npu_axil_pkg.sv | 25 ++
 rtl/npu_axil_master.sv | 184 ++++++++++++++++++
 tb/tb_npu_axil_master.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/npu_axil_pkg.sv
// -----------------------------------------------------------------------------
// npu_axil_pkg
// Shared definitions for the host-side AXI4-Lite initiator:
//   - state_e                : initiator FSM states
//   - RESP_OKAY/SLVERR/DECERR: AXI response codes
//   - DEFAULT_TIMEOUT_CYCLES : default bus-phase stall budget
// -----------------------------------------------------------------------------
package npu_axil_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_WR_RESP,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_RSP
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/npu_axil_master.sv
// -----------------------------------------------------------------------------
// npu_axil_master
// Turns single register commands (one write or one read) into AXI4-Lite
// transactions. One transaction in flight, one buffered response, and a stall
// timeout that aborts with SLVERR.
//
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   cmd_*                    : command request (valid/ready, write, addr,
//                              wdata, wstrb)
//   rsp_*                    : response (valid/ready, rdata, resp, timeout)
//   m_axil_aw*/w*/b*         : AXI4-Lite write channels
//   m_axil_ar*/r*            : AXI4-Lite read channels
//
// Parameter:
//   TIMEOUT_CYCLES           : bus-phase cycles before abort, 0 disables
// -----------------------------------------------------------------------------
module npu_axil_master
  import npu_axil_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_resp,
  output logic        rsp_timeout,
  output logic [31:0] m_axil_awaddr,
  output logic        m_axil_awvalid,
  input  logic        m_axil_awready,
  output logic [31:0] m_axil_wdata,
  output logic [3:0]  m_axil_wstrb,
  output logic        m_axil_wvalid,
  input  logic        m_axil_wready,
  input  logic [1:0]  m_axil_bresp,
  input  logic        m_axil_bvalid,
  output logic        m_axil_bready,
  output logic [31:0] m_axil_araddr,
  output logic        m_axil_arvalid,
  input  logic        m_axil_arready,
  input  logic [31:0] m_axil_rdata,
  input  logic [1:0]  m_axil_rresp,
  input  logic        m_axil_rvalid,
  output logic        m_axil_rready
);

  // A zero timeout still needs a one-bit timer so the declarations stay legal.
  localparam int unsigned TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TIMER_LIMIT = TW'(TIMEOUT_CYCLES);

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d, timer_inc;
  logic          aw_done_q, w_done_q;
  logic [31:0]   addr_q, wdata_q, rdata_q;
  logic [3:0]    wstrb_q;
  logic [1:0]    resp_q;
  logic          timeout_q;

  logic accept, in_bus, aw_hs, w_hs, phase_done, timeout_hit, abort;

  assign accept      = cmd_valid && (state_q == ST_IDLE);
  assign in_bus      = (state_q == ST_WR) || (state_q == ST_WR_RESP) ||
                       (state_q == ST_RD_ADDR) || (state_q == ST_RD_DATA);
  assign aw_hs       = m_axil_awvalid && m_axil_awready;
  assign w_hs        = m_axil_wvalid && m_axil_wready;
  assign timer_inc   = timer_q + 1'b1;
  // Fires on the bus cycle whose count reaches the limit, so valids are held
  // for exactly TIMEOUT_CYCLES cycles before being dropped.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (timer_inc == TIMER_LIMIT);
  // A handshake finishing the current phase wins over the timeout.
  assign abort       = in_bus && timeout_hit && !phase_done;

  // Phase completion for the current state; a write phase ends only when
  // both AW and W have handshaken, possibly on the same cycle.
  always_comb begin
    phase_done = 1'b0;
    unique case (state_q)
      ST_WR:      phase_done = (aw_done_q || aw_hs) && (w_done_q || w_hs);
      ST_WR_RESP: phase_done = m_axil_bvalid;
      ST_RD_ADDR: phase_done = m_axil_arready;
      ST_RD_DATA: phase_done = m_axil_rvalid;
      default:    phase_done = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (cmd_valid) state_d = cmd_write ? ST_WR : ST_RD_ADDR;
      ST_WR:      if (phase_done) state_d = ST_WR_RESP;
                  else if (abort) state_d = ST_RSP;
      ST_WR_RESP: if (phase_done || abort) state_d = ST_RSP;
      ST_RD_ADDR: if (phase_done) state_d = ST_RD_DATA;
                  else if (abort) state_d = ST_RSP;
      ST_RD_DATA: if (phase_done || abort) state_d = ST_RSP;
      ST_RSP:     if (rsp_ready) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs come only from registered state, never from AXI inputs.
  always_comb begin
    cmd_ready      = (state_q == ST_IDLE);
    m_axil_awvalid = (state_q == ST_WR) && !aw_done_q;
    m_axil_wvalid  = (state_q == ST_WR) && !w_done_q;
    m_axil_bready  = (state_q == ST_WR_RESP);
    m_axil_arvalid = (state_q == ST_RD_ADDR);
    m_axil_rready  = (state_q == ST_RD_DATA);
    rsp_valid      = (state_q == ST_RSP);
  end

  // Timer restarts on accept and runs across every bus phase of a transaction.
  always_comb begin
    timer_d = timer_q;
    if (accept)      timer_d = '0;
    else if (in_bus) timer_d = timer_inc;
  end

  // Command payload, write-channel progress and the buffered response.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      resp_q    <= RESP_OKAY;
      timeout_q <= 1'b0;
    end else begin
      timer_q <= timer_d;
      if (accept) begin
        addr_q    <= cmd_addr;
        wdata_q   <= cmd_wdata;
        wstrb_q   <= cmd_wstrb;
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
        timeout_q <= 1'b0;
      end
      if (state_q == ST_WR) begin
        if (aw_hs) aw_done_q <= 1'b1;
        if (w_hs)  w_done_q  <= 1'b1;
      end
      if ((state_q == ST_WR_RESP) && m_axil_bvalid) begin
        resp_q  <= m_axil_bresp;
        rdata_q <= '0;
      end
      if ((state_q == ST_RD_DATA) && m_axil_rvalid) begin
        resp_q  <= m_axil_rresp;
        rdata_q <= m_axil_rdata;
      end
      if (abort) begin
        resp_q    <= RESP_SLVERR;
        rdata_q   <= '0;
        timeout_q <= 1'b1;
      end
    end
  end

  assign m_axil_awaddr = addr_q;
  assign m_axil_araddr = addr_q;
  assign m_axil_wdata  = wdata_q;
  assign m_axil_wstrb  = wstrb_q;
  assign rsp_rdata     = rdata_q;
  assign rsp_resp      = resp_q;
  assign rsp_timeout   = timeout_q;

endmodule

// File: tb/tb_npu_axil_master.sv
// -----------------------------------------------------------------------------
// tb_npu_axil_master
// Directed bench for npu_axil_master (TIMEOUT_CYCLES=16). The bench plays the
// AXI slave and the command/response host by hand, cycle by cycle. Inputs are
// changed and outputs sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_npu_axil_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  npu_axil_master #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .m_axil_awaddr(awaddr), .m_axil_awvalid(awvalid), .m_axil_awready(awready),
    .m_axil_wdata(wdata), .m_axil_wstrb(wstrb), .m_axil_wvalid(wvalid),
    .m_axil_wready(wready), .m_axil_bresp(bresp), .m_axil_bvalid(bvalid),
    .m_axil_bready(bready), .m_axil_araddr(araddr), .m_axil_arvalid(arvalid),
    .m_axil_arready(arready), .m_axil_rdata(rdata), .m_axil_rresp(rresp),
    .m_axil_rvalid(rvalid), .m_axil_rready(rready)
  );

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic wr, input logic [31:0] addr,
                               input logic [31:0] data, input logic [3:0] strb);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = data;
    cmd_wstrb = strb;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    rst = 1'b1;
    cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
    rsp_ready = 0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    arready = 0; rvalid = 0; rdata = 0; rresp = 0;
    tick(); tick();

    // Reset state
    checkOutput("rst_cmd_ready", cmd_ready, 1);
    checkOutput("rst_awvalid", awvalid, 0);
    checkOutput("rst_wvalid", wvalid, 0);
    checkOutput("rst_arvalid", arvalid, 0);
    checkOutput("rst_bready", bready, 0);
    checkOutput("rst_rready", rready, 0);
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_rsp_rdata", rsp_rdata, 0);
    checkOutput("rst_rsp_resp", rsp_resp, 0);
    checkOutput("rst_rsp_timeout", rsp_timeout, 0);
    checkOutput("rst_awaddr", awaddr, 0);
    rst = 1'b0;
    tick();

    // Write 0x00 <- 1, always-ready slave: minimum latency
    awready = 1; wready = 1;
    applyStimulus(1'b1, 32'h0000_0000, 32'h0000_0001, 4'hF);
    checkOutput("w1_c0_cmd_ready", cmd_ready, 1);
    tick();
    cmd_valid = 0;
    checkOutput("w1_c1_awvalid", awvalid, 1);
    checkOutput("w1_c1_wvalid", wvalid, 1);
    checkOutput("w1_c1_awaddr", awaddr, 32'h0000_0000);
    checkOutput("w1_c1_wdata", wdata, 32'h0000_0001);
    checkOutput("w1_c1_wstrb", wstrb, 4'hF);
    checkOutput("w1_c1_cmd_ready", cmd_ready, 0);
    tick();
    checkOutput("w1_c2_bready", bready, 1);
    checkOutput("w1_c2_awvalid", awvalid, 0);
    checkOutput("w1_c2_wvalid", wvalid, 0);
    bvalid = 1; bresp = 2'b00;
    tick();
    bvalid = 0;
    checkOutput("w1_c3_rsp_valid", rsp_valid, 1);
    checkOutput("w1_c3_bready", bready, 0);
    checkOutput("w1_c3_rsp_resp", rsp_resp, 0);
    checkOutput("w1_c3_rsp_rdata", rsp_rdata, 0);
    checkOutput("w1_c3_rsp_timeout", rsp_timeout, 0);
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    checkOutput("w1_done_rsp_valid", rsp_valid, 0);
    checkOutput("w1_done_cmd_ready", cmd_ready, 1);

    // Read 0x38, rvalid two cycles after arready
    arready = 1;
    applyStimulus(1'b0, 32'h0000_0038, 32'h0, 4'h0);
    tick();
    cmd_valid = 0;
    checkOutput("r1_c1_arvalid", arvalid, 1);
    checkOutput("r1_c1_araddr", araddr, 32'h0000_0038);
    checkOutput("r1_c1_awvalid", awvalid, 0);
    tick();
    checkOutput("r1_c2_arvalid", arvalid, 0);
    checkOutput("r1_c2_rready", rready, 1);
    tick();
    checkOutput("r1_c3_rready", rready, 1);
    rvalid = 1; rdata = 32'h0000_0001; rresp = 2'b00;
    tick();
    rvalid = 0; rdata = 32'h0;
    checkOutput("r1_rsp_valid", rsp_valid, 1);
    checkOutput("r1_rsp_rdata", rsp_rdata, 32'h0000_0001);
    checkOutput("r1_rsp_resp", rsp_resp, 0);
    checkOutput("r1_rsp_timeout", rsp_timeout, 0);
    rsp_ready = 1;
    tick();
    rsp_ready = 0;

    // Write 0x14 <- 0x8000_0000, W immediate, AW delayed 3 cycles
    awready = 0; wready = 1;
    applyStimulus(1'b1, 32'h0000_0014, 32'h8000_0000, 4'hF);
    tick();
    cmd_valid = 0;
    checkOutput("w2_c1_awvalid", awvalid, 1);
    checkOutput("w2_c1_wvalid", wvalid, 1);
    tick();
    checkOutput("w2_c2_wvalid", wvalid, 0);
    checkOutput("w2_c2_awvalid", awvalid, 1);
    checkOutput("w2_c2_awaddr", awaddr, 32'h0000_0014);
    checkOutput("w2_c2_wdata_hold", wdata, 32'h8000_0000);
    tick();
    checkOutput("w2_c3_awvalid", awvalid, 1);
    checkOutput("w2_c3_wvalid", wvalid, 0);
    checkOutput("w2_c3_bready", bready, 0);
    tick();
    checkOutput("w2_c4_awvalid", awvalid, 1);
    checkOutput("w2_c4_awaddr", awaddr, 32'h0000_0014);
    awready = 1;
    tick();
    checkOutput("w2_c5_awvalid", awvalid, 0);
    checkOutput("w2_c5_bready", bready, 1);
    bvalid = 1; bresp = 2'b00;
    tick();
    bvalid = 0;
    checkOutput("w2_rsp_valid", rsp_valid, 1);
    checkOutput("w2_rsp_resp", rsp_resp, 0);
    checkOutput("w2_bready_single", bready, 0);
    rsp_ready = 1;
    tick();
    rsp_ready = 0;

    // Read with arready stuck low: abort after 16 bus cycles
    arready = 0;
    applyStimulus(1'b0, 32'h0000_0020, 32'h0, 4'h0);
    tick();
    cmd_valid = 0;
    checkOutput("to_c1_arvalid", arvalid, 1);
    repeat (15) tick();
    checkOutput("to_c16_arvalid", arvalid, 1);
    checkOutput("to_c16_rsp_valid", rsp_valid, 0);
    tick();
    checkOutput("to_c17_arvalid", arvalid, 0);
    checkOutput("to_rsp_valid", rsp_valid, 1);
    checkOutput("to_rsp_timeout", rsp_timeout, 1);
    checkOutput("to_rsp_resp", rsp_resp, 2'b10);
    checkOutput("to_rsp_rdata", rsp_rdata, 0);
    rsp_ready = 1;
    tick();
    rsp_ready = 0;

    // Follow-up read to a responsive slave clears the timeout flag
    arready = 1;
    applyStimulus(1'b0, 32'h0000_0038, 32'h0, 4'h0);
    tick();
    cmd_valid = 0;
    checkOutput("r2_c1_timeout_clr", rsp_timeout, 0);
    tick();
    rvalid = 1; rdata = 32'hCAFE_0001; rresp = 2'b00;
    tick();
    rvalid = 0; rdata = 32'h0;
    checkOutput("r2_rsp_valid", rsp_valid, 1);
    checkOutput("r2_rsp_timeout", rsp_timeout, 0);
    checkOutput("r2_rsp_resp", rsp_resp, 0);
    checkOutput("r2_rsp_rdata", rsp_rdata, 32'hCAFE_0001);
    rsp_ready = 1;
    tick();
    rsp_ready = 0;

    // DECERR write response held under rsp_ready backpressure
    awready = 1; wready = 1;
    applyStimulus(1'b1, 32'h0000_0004, 32'h1234_5678, 4'h3);
    tick();
    cmd_valid = 0;
    tick();
    bvalid = 1; bresp = 2'b11;
    tick();
    bvalid = 0; bresp = 2'b00;
    applyStimulus(1'b1, 32'h0000_0008, 32'hFFFF_FFFF, 4'hF);
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_rsp_valid", rsp_valid, 1);
      checkOutput("bp_rsp_resp", rsp_resp, 2'b11);
      checkOutput("bp_rsp_rdata", rsp_rdata, 0);
      checkOutput("bp_cmd_ready", cmd_ready, 0);
      checkOutput("bp_awvalid", awvalid, 0);
      tick();
    end
    cmd_valid = 0;
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    checkOutput("bp_after_cmd_ready", cmd_ready, 1);
    checkOutput("bp_after_awvalid", awvalid, 0);
    checkOutput("bp_after_awaddr", awaddr, 32'h0000_0004);

    // Reset during RD_DATA drops everything; late rvalid is ignored
    arready = 1;
    applyStimulus(1'b0, 32'h0000_0040, 32'h0, 4'h0);
    tick();
    cmd_valid = 0;
    tick();
    checkOutput("rr_c2_rready", rready, 1);
    rst = 1;
    tick();
    rst = 0;
    checkOutput("rr_arvalid", arvalid, 0);
    checkOutput("rr_rready", rready, 0);
    checkOutput("rr_rsp_valid", rsp_valid, 0);
    checkOutput("rr_cmd_ready", cmd_ready, 1);
    rvalid = 1; rdata = 32'hDEAD_BEEF; rresp = 2'b00;
    tick();
    rvalid = 0; rdata = 32'h0;
    checkOutput("rr_late_rsp_valid", rsp_valid, 0);
    checkOutput("rr_late_rsp_rdata", rsp_rdata, 0);
    checkOutput("rr_late_cmd_ready", cmd_ready, 1);
    tick();
    checkOutput("rr_idle_rsp_valid", rsp_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
